// File: rtl/alu_share_arbiter.sv
// Round-robin shared ALU with RV64 W-form fix-up; 1-cycle fire-to-result latency.
// Single-entry result stage: requesters see ready=0 while a held result is stalled.
package alu_share_pkg;
   typedef enum logic [3:0] {
      OP_ALU_ADD  = 4'd0,
      OP_ALU_SUB  = 4'd1,
      OP_ALU_SLL  = 4'd2,
      OP_ALU_SLT  = 4'd3,
      OP_ALU_SLTU = 4'd4,
      OP_ALU_XOR  = 4'd5,
      OP_ALU_SRL  = 4'd6,
      OP_ALU_SRA  = 4'd7,
      OP_ALU_OR   = 4'd8,
      OP_ALU_AND  = 4'd9
   } decode_alu_op_t;
endpackage

module arithmetic_unit
   import alu_share_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            i_en,
   input  decode_alu_op_t  i_op,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   output logic [XLEN-1:0] o_dest
);
   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;

   always_comb begin
      shamt  = i_src2[SHW-1:0];
      o_dest = '0;
      if (i_en) begin
         case (i_op)
            OP_ALU_ADD:  o_dest = i_src1 + i_src2;
            OP_ALU_SUB:  o_dest = i_src1 - i_src2;
            OP_ALU_SLL:  o_dest = i_src1 << shamt;
            OP_ALU_SLT:  o_dest = {{(XLEN-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
            OP_ALU_SLTU: o_dest = {{(XLEN-1){1'b0}}, i_src1 < i_src2};
            OP_ALU_XOR:  o_dest = i_src1 ^ i_src2;
            OP_ALU_SRL:  o_dest = i_src1 >> shamt;
            OP_ALU_SRA:  o_dest = XLEN'($signed(i_src1) >>> shamt);
            OP_ALU_OR:   o_dest = i_src1 | i_src2;
            OP_ALU_AND:  o_dest = i_src1 & i_src2;
            default:     o_dest = '0;
         endcase
      end
   end
endmodule

module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 64,
   parameter int TAG_W   = 6,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   output logic [NUM_REQ-1:0]               o_req_ready,
   input  decode_alu_op_t [NUM_REQ-1:0]     i_req_op,
   input  logic [NUM_REQ-1:0]               i_req_w32,
   input  logic [NUM_REQ-1:0][XLEN-1:0]     i_req_src1,
   input  logic [NUM_REQ-1:0][XLEN-1:0]     i_req_src2,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]    i_req_tag,
   output logic                             o_resp_valid,
   input  logic                             i_resp_ready,
   output logic [XLEN-1:0]                  o_resp_dest,
   output logic [TAG_W-1:0]                 o_resp_tag,
   output logic [ID_W-1:0]                  o_resp_id,
   output logic                             o_busy
);
   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   logic                resp_vld_q, resp_vld_d;
   logic [XLEN-1:0]     resp_dest_q, resp_dest_d;
   logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;
   logic [ID_W-1:0]     resp_id_q, resp_id_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;

   logic                accept_en;
   logic                grant_vld;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W:0]       scan_sum;
   logic                fire;

   decode_alu_op_t      alu_op;
   logic                alu_w32;
   logic [XLEN-1:0]     alu_src1, alu_src2, alu_dest, fix_dest;
   logic                no_w_form;

   assign accept_en = ~resp_vld_q | i_resp_ready;

   // Scan starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_sum  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k + 1);
         if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
         if (!grant_vld && i_req_valid[scan_sum[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_sum[ID_W-1:0];
         end
      end
   end

   assign fire = grant_vld & accept_en & i_rst_n;

   always_comb begin
      o_req_ready = '0;
      if (fire) o_req_ready[grant_idx] = 1'b1;
   end

   // Operand fix-up makes the 64-bit ALU produce W-form results in its low word.
   always_comb begin
      alu_op   = OP_ALU_ADD;
      alu_w32  = 1'b0;
      alu_src1 = '0;
      alu_src2 = '0;
      if (fire) begin
         alu_op   = i_req_op[grant_idx];
         alu_w32  = i_req_w32[grant_idx];
         alu_src1 = i_req_src1[grant_idx];
         alu_src2 = i_req_src2[grant_idx];
      end
      if (alu_w32) begin
         if (alu_op == OP_ALU_SRL) alu_src1 = {{(XLEN-32){1'b0}}, alu_src1[31:0]};
         if (alu_op == OP_ALU_SRA) alu_src1 = {{(XLEN-32){alu_src1[31]}}, alu_src1[31:0]};
         if (alu_op == OP_ALU_SLL || alu_op == OP_ALU_SRL || alu_op == OP_ALU_SRA)
            alu_src2 = {{(XLEN-5){1'b0}}, alu_src2[4:0]};
      end
   end

   arithmetic_unit #(.XLEN(XLEN)) u_alu (
      .i_en   (fire),
      .i_op   (alu_op),
      .i_src1 (alu_src1),
      .i_src2 (alu_src2),
      .o_dest (alu_dest)
   );

   always_comb begin
      no_w_form = (alu_op == OP_ALU_SLT) || (alu_op == OP_ALU_SLTU) ||
                  (alu_op == OP_ALU_AND) || (alu_op == OP_ALU_OR)   ||
                  (alu_op == OP_ALU_XOR);
      fix_dest  = alu_dest;
      if (alu_w32 && !no_w_form) fix_dest = {{(XLEN-32){alu_dest[31]}}, alu_dest[31:0]};
   end

   always_comb begin
      resp_vld_d  = resp_vld_q;
      resp_dest_d = resp_dest_q;
      resp_tag_d  = resp_tag_q;
      resp_id_d   = resp_id_q;
      ptr_d       = ptr_q;
      if (fire) begin
         resp_vld_d  = 1'b1;
         resp_dest_d = fix_dest;
         resp_tag_d  = i_req_tag[grant_idx];
         resp_id_d   = grant_idx;
         ptr_d       = grant_idx;
      end else if (i_resp_ready) begin
         resp_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         resp_vld_q  <= 1'b0;
         resp_dest_q <= '0;
         resp_tag_q  <= '0;
         resp_id_q   <= '0;
         ptr_q       <= ID_W'(NUM_REQ - 1);
      end else begin
         resp_vld_q  <= resp_vld_d;
         resp_dest_q <= resp_dest_d;
         resp_tag_q  <= resp_tag_d;
         resp_id_q   <= resp_id_d;
         ptr_q       <= ptr_d;
      end
   end

   assign o_resp_valid = resp_vld_q;
   assign o_resp_dest  = resp_dest_q;
   assign o_resp_tag   = resp_tag_q;
   assign o_resp_id    = resp_id_q;
   assign o_busy       = resp_vld_q & ~i_resp_ready;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: op table plus round-robin, stall and reset sequences.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic                  i_clk = 1'b0;
   logic                  i_rst_n;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   decode_alu_op_t [1:0]  req_op;
   logic [1:0]            req_w32;
   logic [1:0][63:0]      req_src1;
   logic [1:0][63:0]      req_src2;
   logic [1:0][5:0]       req_tag;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [63:0]           resp_dest;
   logic [5:0]            resp_tag;
   logic [0:0]            resp_id;
   logic                  busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_share_arbiter #(.NUM_REQ(2), .XLEN(64), .TAG_W(6)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op     (req_op),
      .i_req_w32    (req_w32),
      .i_req_src1   (req_src1),
      .i_req_src2   (req_src2),
      .i_req_tag    (req_tag),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_dest  (resp_dest),
      .o_resp_tag   (resp_tag),
      .o_resp_id    (resp_id),
      .o_busy       (busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input decode_alu_op_t op, input logic w,
                          input logic [63:0] s1, input logic [63:0] s2, input logic [5:0] t);
      req_op[r]   = op;
      req_w32[r]  = w;
      req_src1[r] = s1;
      req_src2[r] = s2;
      req_tag[r]  = t;
   endtask

   typedef struct {
      int             req;
      decode_alu_op_t op;
      logic           w32;
      logic [63:0]    s1;
      logic [63:0]    s2;
      logic [63:0]    exp;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      logic [1:0] er;
      vecs[0]  = '{0, OP_ALU_ADD,  1'b0, 64'd5, 64'd7, 64'd12};
      vecs[1]  = '{1, OP_ALU_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
      vecs[2]  = '{0, OP_ALU_SRA,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 64'hFFFF_FFFF_F800_0000};
      vecs[3]  = '{1, OP_ALU_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 64'h0000_0000_0800_0000};
      vecs[4]  = '{0, OP_ALU_SLL,  1'b0, 64'd1, 64'd40, 64'h0000_0100_0000_0000};
      vecs[5]  = '{1, OP_ALU_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
      vecs[6]  = '{0, OP_ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
      vecs[7]  = '{1, OP_ALU_SUB,  1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[8]  = '{0, decode_alu_op_t'(4'hF), 1'b0, 64'd5, 64'd5, 64'd0};
      vecs[9]  = '{1, OP_ALU_AND,  1'b1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
      vecs[10] = '{0, OP_ALU_SLL,  1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000};
      vecs[11] = '{1, OP_ALU_XOR,  1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00};
      vecs[12] = '{0, OP_ALU_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
      vecs[13] = '{1, OP_ALU_OR,   1'b0, 64'h00F0, 64'h0F00, 64'h0FF0};

      i_rst_n    = 1'b0;
      resp_ready = 1'b1;
      req_valid  = 2'b11;
      set_req(0, OP_ALU_ADD, 1'b0, 64'd1, 64'd1, 6'd1);
      set_req(1, OP_ALU_ADD, 1'b0, 64'd2, 64'd2, 6'd2);
      repeat (2) @(negedge i_clk);
      chk("reset_ready", 64'(req_ready), 64'd0);
      chk("reset_valid", 64'(resp_valid), 64'd0);
      chk("reset_dest", resp_dest, 64'd0);
      chk("reset_tag", 64'(resp_tag), 64'd0);
      chk("reset_id", 64'(resp_id), 64'd0);
      req_valid = 2'b00;
      i_rst_n   = 1'b1;
      @(negedge i_clk);

      // Op table, one requester at a time, result checked the following cycle.
      for (int i = 0; i < NV; i++) begin
         req_valid = 2'b00;
         req_valid[vecs[i].req] = 1'b1;
         set_req(vecs[i].req, vecs[i].op, vecs[i].w32, vecs[i].s1, vecs[i].s2, 6'(i + 3));
         #1;
         er = 2'b00;
         er[vecs[i].req] = 1'b1;
         chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(er));
         @(posedge i_clk);
         @(negedge i_clk);
         req_valid = 2'b00;
         chk($sformatf("vec%0d_valid", i), 64'(resp_valid), 64'd1);
         chk($sformatf("vec%0d_dest", i), resp_dest, vecs[i].exp);
         chk($sformatf("vec%0d_tag", i), 64'(resp_tag), 64'(i + 3));
         chk($sformatf("vec%0d_id", i), 64'(resp_id), 64'(vecs[i].req));
      end

      // Round robin: last table winner was req1, so req0 wins first.
      set_req(0, OP_ALU_ADD, 1'b0, 64'd10, 64'd20, 6'd10);
      set_req(1, OP_ALU_SUB, 1'b0, 64'd50, 64'd8, 6'd11);
      req_valid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c > 0) begin
            chk($sformatf("rr%0d_valid", c), 64'(resp_valid), 64'd1);
            chk($sformatf("rr%0d_id", c), 64'(resp_id), 64'((c - 1) % 2));
            chk($sformatf("rr%0d_dest", c), resp_dest, ((c - 1) % 2 == 0) ? 64'd30 : 64'd42);
         end
         if (c < 4) begin
            chk($sformatf("rr%0d_ready", c), 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge i_clk);
            @(negedge i_clk);
            if (c == 3) req_valid = 2'b00;
         end
      end

      // Stall for 3 cycles with req0 pending.
      resp_ready = 1'b0;
      set_req(0, OP_ALU_ADD, 1'b0, 64'd100, 64'd1, 6'd20);
      req_valid = 2'b01;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("stall%0d_ready", s), 64'(req_ready), 64'd0);
         chk($sformatf("stall%0d_valid", s), 64'(resp_valid), 64'd1);
         chk($sformatf("stall%0d_dest", s), resp_dest, 64'd42);
         chk($sformatf("stall%0d_tag", s), 64'(resp_tag), 64'd11);
         chk($sformatf("stall%0d_id", s), 64'(resp_id), 64'd1);
         chk($sformatf("stall%0d_busy", s), 64'(busy), 64'd1);
         @(negedge i_clk);
      end
      resp_ready = 1'b1;
      #1;
      chk("drain_ready", 64'(req_ready), 64'd1);
      chk("drain_busy", 64'(busy), 64'd0);
      @(negedge i_clk);
      req_valid = 2'b00;
      chk("drain_valid", 64'(resp_valid), 64'd1);
      chk("drain_dest", resp_dest, 64'd101);
      chk("drain_tag", 64'(resp_tag), 64'd20);
      chk("drain_id", 64'(resp_id), 64'd0);
      @(negedge i_clk);
      chk("idle_valid", 64'(resp_valid), 64'd0);

      // Hold a req0 result, then reset asynchronously mid-stall.
      set_req(0, OP_ALU_ADD, 1'b0, 64'd7, 64'd7, 6'd30);
      req_valid = 2'b01;
      @(negedge i_clk);
      req_valid  = 2'b00;
      resp_ready = 1'b0;
      chk("prerst_valid", 64'(resp_valid), 64'd1);
      chk("prerst_dest", resp_dest, 64'd14);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(resp_valid), 64'd0);
      chk("arst_dest", resp_dest, 64'd0);
      @(negedge i_clk);
      i_rst_n    = 1'b1;
      resp_ready = 1'b1;
      req_valid  = 2'b11;
      #1;
      chk("postrst_ready", 64'(req_ready), 64'd1);
      @(negedge i_clk);
      req_valid = 2'b00;
      chk("postrst_valid", 64'(resp_valid), 64'd1);
      chk("postrst_id", 64'(resp_id), 64'd0);
      chk("postrst_dest", resp_dest, 64'd14);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
